// File: rtl/rx_trailer_hdr_decode_pkg.sv
// Shared types and constants for the receive trailer check and packet header decoder.
// The HEC LFSR helper also pulls its polynomial from here.
package rx_trailer_hdr_decode_pkg;

   localparam int TRAILER_LEN = 4;
   localparam int HDR_BITS    = 18;
   localparam int FEC_REP     = 3;
   localparam int INFO_BITS   = 10;

   // x^8+x^7+x^5+x^2+x+1 with the x^8 term implicit
   localparam logic [7:0] HEC_POLY = 8'hA7;

   // x^7+x^4+1: feedback from bit 6 into bits 0 and 4
   localparam logic [6:0] WHITEN_TAPS    = 7'h11;
   localparam int         WHITEN_OUT_BIT = 6;

   localparam int LT_ADDR_LSB = 0;
   localparam int LT_ADDR_W   = 3;
   localparam int TYPE_LSB    = 3;
   localparam int TYPE_W      = 4;
   localparam int FLOW_BIT    = 7;
   localparam int ARQN_BIT    = 8;
   localparam int SEQN_BIT    = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRAILER = 2'd1,
      ST_HEADER  = 2'd2,
      ST_CHECK   = 2'd3
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bt_hec_lfsr.sv
// Serial HEC generator: Galois LFSR seeded with the UAP, one data bit per shift.
// Shared between the header receive and header transmit paths.
module bt_hec_lfsr
   import rx_trailer_hdr_decode_pkg::*;
(
   input  logic       clk_6M,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] init,
   input  logic       shift,
   input  logic       din,
   output logic [7:0] crc
);

   logic fb;

   assign fb = din ^ crc[7];

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         crc <= 8'h00;
      end else if (load) begin
         crc <= init;
      end else if (shift) begin
         crc <= {crc[6:0], 1'b0} ^ (fb ? HEC_POLY : 8'h00);
      end
   end

endmodule

// File: rtl/rx_trailer_hdr_decode.sv
// Checks the access-code trailer, then majority-decodes, de-whitens and HEC-checks
// the FEC-1/3 packet header, bit-paced by p_1us.
module rx_trailer_hdr_decode
   import rx_trailer_hdr_decode_pkg::*;
(
   input  logic       clk_6M,
   input  logic       rst,
   input  logic       p_1us,
   input  logic       rx_bit,
   input  logic       rx_trailer_st_p,
   input  logic       ref_sync_msb,
   input  logic [7:0] regi_uap,
   input  logic       whiten_en,
   input  logic [6:0] whiten_init,
   input  logic       rx_abort,
   output logic       busy,
   output logic       trailer_err,
   output logic [2:0] hdr_lt_addr,
   output logic [3:0] hdr_type,
   output logic       hdr_flow,
   output logic       hdr_arqn,
   output logic       hdr_seqn,
   output logic       hec_ok,
   output logic       hdr_valid_p
);

   state_t                 state, state_nxt;
   logic [1:0]             trail_cnt;
   logic [1:0]             rep_cnt;
   logic [4:0]             bit_cnt;
   logic [1:0]             samp;
   logic [6:0]             whiten_lfsr;
   logic [INFO_BITS-1:0]   info;
   logic [7:0]             hec_rx;
   logic [7:0]             hec_crc;
   logic                   abort, start, trail_exp, dec_bit, triple_done, hec_shift;

   // Abort outranks a restart; a start strobe never consumes the bit it coincides with.
   assign abort       = rx_abort && (state != ST_IDLE);
   assign start       = rx_trailer_st_p && !abort && (state != ST_CHECK);
   assign trail_exp   = ~(trail_cnt[0] ^ ref_sync_msb);
   assign dec_bit     = maj3(samp[1], samp[0], rx_bit) ^ (whiten_en & whiten_lfsr[WHITEN_OUT_BIT]);
   assign triple_done = (state == ST_HEADER) && p_1us && !start && !abort &&
                        (rep_cnt == 2'(FEC_REP - 1));
   assign hec_shift   = triple_done && (bit_cnt < 5'(INFO_BITS));
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge clk_6M) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    state_nxt = ST_IDLE;
         ST_TRAILER: if (p_1us && trail_cnt == 2'(TRAILER_LEN - 1)) state_nxt = ST_HEADER;
         ST_HEADER:  if (triple_done && bit_cnt == 5'(HDR_BITS - 1)) state_nxt = ST_CHECK;
         ST_CHECK:   state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
      if (start) state_nxt = ST_TRAILER;
      if (abort) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         trail_cnt   <= '0;
         rep_cnt     <= '0;
         bit_cnt     <= '0;
         samp        <= '0;
         whiten_lfsr <= '0;
         info        <= '0;
         hec_rx      <= '0;
         trailer_err <= 1'b0;
         hdr_lt_addr <= '0;
         hdr_type    <= '0;
         hdr_flow    <= 1'b0;
         hdr_arqn    <= 1'b0;
         hdr_seqn    <= 1'b0;
         hec_ok      <= 1'b0;
         hdr_valid_p <= 1'b0;
      end else begin
         hdr_valid_p <= 1'b0;
         if (start) begin
            trail_cnt   <= '0;
            rep_cnt     <= '0;
            bit_cnt     <= '0;
            samp        <= '0;
            hec_rx      <= '0;
            trailer_err <= 1'b0;
            whiten_lfsr <= whiten_init;
         end else if (!abort) begin
            case (state)
               ST_TRAILER: begin
                  if (p_1us) begin
                     if (rx_bit != trail_exp) trailer_err <= 1'b1;
                     trail_cnt <= trail_cnt + 2'd1;
                  end
               end
               ST_HEADER: begin
                  if (p_1us) begin
                     samp <= {samp[0], rx_bit};
                     if (triple_done) begin
                        rep_cnt <= '0;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (whiten_en)
                           whiten_lfsr <= {whiten_lfsr[5:0], 1'b0} ^
                                          (whiten_lfsr[WHITEN_OUT_BIT] ? WHITEN_TAPS : 7'h00);
                        if (bit_cnt < 5'(INFO_BITS)) info   <= {dec_bit, info[INFO_BITS-1:1]};
                        else                         hec_rx <= {hec_rx[6:0], dec_bit};
                     end else begin
                        rep_cnt <= rep_cnt + 2'd1;
                     end
                  end
               end
               ST_CHECK: begin
                  hdr_lt_addr <= info[LT_ADDR_LSB +: LT_ADDR_W];
                  hdr_type    <= info[TYPE_LSB +: TYPE_W];
                  hdr_flow    <= info[FLOW_BIT];
                  hdr_arqn    <= info[ARQN_BIT];
                  hdr_seqn    <= info[SEQN_BIT];
                  hec_ok      <= (hec_rx == hec_crc);
                  hdr_valid_p <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   bt_hec_lfsr u_hec (
      .clk_6M (clk_6M),
      .rst    (rst),
      .load   (start),
      .init   (regi_uap),
      .shift  (hec_shift),
      .din    (dec_bit),
      .crc    (hec_crc)
   );

endmodule

// File: tb/tb_rx_trailer_hdr_decode.sv
// Directed bench for rx_trailer_hdr_decode: clean, corrupted, whitened, aborted,
// restarted and reset-interrupted packets against a small header model.
module tb_rx_trailer_hdr_decode;

   logic       clk_6M = 1'b0;
   logic       rst;
   logic       p_1us;
   logic       rx_bit;
   logic       rx_trailer_st_p;
   logic       ref_sync_msb;
   logic [7:0] regi_uap;
   logic       whiten_en;
   logic [6:0] whiten_init;
   logic       rx_abort;
   logic       busy;
   logic       trailer_err;
   logic [2:0] hdr_lt_addr;
   logic [3:0] hdr_type;
   logic       hdr_flow;
   logic       hdr_arqn;
   logic       hdr_seqn;
   logic       hec_ok;
   logic       hdr_valid_p;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          vcnt    = 0;
   logic [53:0] raw_v;

   rx_trailer_hdr_decode dut (
      .clk_6M          (clk_6M),
      .rst             (rst),
      .p_1us           (p_1us),
      .rx_bit          (rx_bit),
      .rx_trailer_st_p (rx_trailer_st_p),
      .ref_sync_msb    (ref_sync_msb),
      .regi_uap        (regi_uap),
      .whiten_en       (whiten_en),
      .whiten_init     (whiten_init),
      .rx_abort        (rx_abort),
      .busy            (busy),
      .trailer_err     (trailer_err),
      .hdr_lt_addr     (hdr_lt_addr),
      .hdr_type        (hdr_type),
      .hdr_flow        (hdr_flow),
      .hdr_arqn        (hdr_arqn),
      .hdr_seqn        (hdr_seqn),
      .hec_ok          (hec_ok),
      .hdr_valid_p     (hdr_valid_p)
   );

   always #83 clk_6M = ~clk_6M;

   always @(negedge clk_6M) if (hdr_valid_p) vcnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_6M);
      #1;
   endtask

   task automatic strobe(input logic b);
      p_1us = 1'b1;
      rx_bit = b;
      cyc();
      p_1us = 1'b0;
      rx_bit = 1'($urandom_range(0, 1));
      cyc();
      cyc();
   endtask

   task automatic start_pkt();
      rx_trailer_st_p = 1'b1;
      p_1us = 1'b1;
      rx_bit = 1'($urandom_range(0, 1));
      cyc();
      rx_trailer_st_p = 1'b0;
      p_1us = 1'b0;
      cyc();
      cyc();
   endtask

   function automatic logic [7:0] hec_calc(input logic [7:0] uap, input logic [9:0] info);
      logic [7:0] c;
      logic       fb;
      c = uap;
      for (int i = 0; i < 10; i++) begin
         fb = info[i] ^ c[7];
         c = {c[6:0], 1'b0} ^ (fb ? 8'hA7 : 8'h00);
      end
      return c;
   endfunction

   function automatic logic [17:0] air_hdr(input logic [9:0] info, input logic [7:0] hec,
                                           input logic wen, input logic [6:0] winit);
      logic [17:0] h, a;
      logic [6:0]  w;
      h[9:0] = info;
      for (int k = 0; k < 8; k++) h[10+k] = hec[7-k];
      w = winit;
      for (int i = 0; i < 18; i++) begin
         a[i] = h[i] ^ (wen & w[6]);
         if (wen) w = {w[5:0], 1'b0} ^ (w[6] ? 7'h11 : 7'h00);
      end
      return a;
   endfunction

   task automatic build_raw(input logic [17:0] air, input bit corrupt, input int flip_idx);
      logic b;
      for (int i = 0; i < 18; i++) begin
         for (int r = 0; r < 3; r++) begin
            b = air[i];
            if (corrupt && r == (i % 3)) b = ~b;
            if (i == flip_idx) b = ~b;
            raw_v[i*3+r] = b;
         end
      end
   endtask

   task automatic send_raw(input int from, input int to);
      for (int k = from; k < to; k++) strobe(raw_v[k]);
   endtask

   task automatic send_trailer(input logic [3:0] trl);
      for (int i = 3; i >= 0; i--) strobe(trl[i]);
   endtask

   task automatic run_pkt(input string tag, input logic msb, input logic [3:0] trl,
                          input logic [2:0] lt, input logic [3:0] ty, input logic fl,
                          input logic ar, input logic sq, input logic wen,
                          input logic [6:0] winit, input bit corrupt, input int flip_idx,
                          input logic exp_terr, input logic exp_hec_ok);
      logic [9:0] info;
      logic [7:0] hec;
      int         v0;
      info = {sq, ar, fl, ty, lt};
      hec = hec_calc(regi_uap, info);
      ref_sync_msb = msb;
      whiten_en = wen;
      whiten_init = winit;
      build_raw(air_hdr(info, hec, wen, winit), corrupt, flip_idx);
      v0 = vcnt;
      start_pkt();
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      check({tag, "_terr_clear"}, 32'(trailer_err), 32'd0);
      send_trailer(trl);
      send_raw(0, 53);
      p_1us = 1'b1;
      rx_bit = raw_v[53];
      cyc();
      p_1us = 1'b0;
      check({tag, "_valid_early"}, 32'(hdr_valid_p), 32'd0);
      check({tag, "_busy_check"}, 32'(busy), 32'd1);
      cyc();
      check({tag, "_valid"}, 32'(hdr_valid_p), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_lt_addr"}, 32'(hdr_lt_addr), 32'(lt));
      check({tag, "_type"}, 32'(hdr_type), 32'(ty));
      check({tag, "_flow"}, 32'(hdr_flow), 32'(fl));
      check({tag, "_arqn"}, 32'(hdr_arqn), 32'(ar));
      check({tag, "_seqn"}, 32'(hdr_seqn), 32'(sq));
      check({tag, "_hec_ok"}, 32'(hec_ok), 32'(exp_hec_ok));
      check({tag, "_terr"}, 32'(trailer_err), 32'(exp_terr));
      cyc();
      check({tag, "_valid_pulse"}, 32'(hdr_valid_p), 32'd0);
      check({tag, "_valid_count"}, 32'(vcnt - v0), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_terr"}, 32'(trailer_err), 32'd0);
      check({tag, "_fields"}, 32'({hdr_lt_addr, hdr_type, hdr_flow, hdr_arqn, hdr_seqn}), 32'd0);
      check({tag, "_hec_ok"}, 32'(hec_ok), 32'd0);
      check({tag, "_valid"}, 32'(hdr_valid_p), 32'd0);
   endtask

   initial begin
      int v0;
      rst = 1'b1;
      p_1us = 1'b0;
      rx_bit = 1'b0;
      rx_trailer_st_p = 1'b0;
      ref_sync_msb = 1'b0;
      regi_uap = 8'h47;
      whiten_en = 1'b0;
      whiten_init = 7'h00;
      rx_abort = 1'b0;
      cyc();
      cyc();
      cyc();
      check_all_zero("reset");
      rst = 1'b0;
      cyc();

      // clean packet, then the same with one bad sample per triple
      run_pkt("t1", 1'b0, 4'b1010, 3'd5, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 0, -1, 1'b0, 1'b1);
      run_pkt("t2", 1'b0, 4'b1010, 3'd5, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1, -1, 1'b0, 1'b1);

      // inverted reference: 1010 on air is now a trailer error
      run_pkt("t3", 1'b1, 4'b1010, 3'd6, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 0, -1, 1'b1, 1'b1);

      // whitened header, then the same with one HEC triple fully inverted
      run_pkt("t4a", 1'b0, 4'b1010, 3'd3, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 7'h55, 0, -1, 1'b0, 1'b1);
      run_pkt("t4b", 1'b0, 4'b1010, 3'd3, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 7'h55, 0, 12, 1'b0, 1'b0);

      // abort after 20 raw header bits
      ref_sync_msb = 1'b0;
      whiten_en = 1'b0;
      build_raw(air_hdr(10'h2A5, 8'h3C, 1'b0, 7'h00), 0, -1);
      v0 = vcnt;
      start_pkt();
      send_trailer(4'b1010);
      send_raw(0, 20);
      rx_abort = 1'b1;
      cyc();
      rx_abort = 1'b0;
      check("t5_abort_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 12; i++) cyc();
      check("t5_abort_novalid", 32'(vcnt - v0), 32'd0);
      check("t5_abort_lt_addr", 32'(hdr_lt_addr), 32'd3);
      check("t5_abort_type", 32'(hdr_type), 32'h9);
      check("t5_abort_hec_ok", 32'(hec_ok), 32'd0);

      // restart in the middle of a header
      v0 = vcnt;
      start_pkt();
      send_trailer(4'b1010);
      send_raw(0, 30);
      check("t5_cut_novalid", 32'(vcnt - v0), 32'd0);
      run_pkt("t5r", 1'b0, 4'b1010, 3'd2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 0, -1, 1'b0, 1'b1);

      // reset in HEADER with a trailer error pending
      ref_sync_msb = 1'b0;
      start_pkt();
      send_trailer(4'b0101);
      check("t6_terr_before_rst", 32'(trailer_err), 32'd1);
      send_raw(0, 10);
      rst = 1'b1;
      cyc();
      check_all_zero("t6_rst");
      cyc();
      rst = 1'b0;
      cyc();
      run_pkt("t6", 1'b0, 4'b1010, 3'd7, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 7'h00, 0, -1, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_trailer_hdr_decode.md
Name: rx_trailer_hdr_decode

Overview:
- Downstream stage of the access-code correlator.
- Starts on the correlator's rx_trailer_st_p strobe. It checks the 4-bit trailer, then majority-decodes the 54-bit FEC-1/3 packet header into 18 bits, de-whitens it, and verifies the HEC against the UAP.
- Delivers the header fields plus a one-cycle valid pulse to the packet receive controller.
- Bit timing follows the 1 us strobe p_1us in the clk_6M domain.

Parameters:
- TRAILER_LEN, 4, number of trailer bits checked after the sync word.
- HDR_BITS, 18, decoded header bits (10 info + 8 HEC).
- FEC_REP, 3, repetition factor of the header FEC.

Ports:
- clk_6M  in  1  system clock, 6 MHz.
- rst  in  1  reset, synchronous, active-high.
- p_1us  in  1  one-clk_6M-wide bit strobe; rx_bit is valid when this is high.
- rx_bit  in  1  demodulated air bit.
- rx_trailer_st_p  in  1  correlator hit; coincident with the p_1us of the last sync bit.
- ref_sync_msb  in  1  bit 63 of the reference sync word; selects the trailer pattern.
- regi_uap  in  8  HEC LFSR initial value.
- whiten_en  in  1  enables header de-whitening.
- whiten_init  in  7  whitening LFSR seed, sampled on rx_trailer_st_p.
- rx_abort  in  1  receive window closed; cancels decoding.
- busy  out  1  high in TRAILER, HEADER or CHECK.
- trailer_err  out  1  sticky per packet: any trailer bit mismatched.
- hdr_lt_addr  out  3  decoded bits 0..2.
- hdr_type  out  4  decoded bits 3..6.
- hdr_flow  out  1  decoded bit 7.
- hdr_arqn  out  1  decoded bit 8.
- hdr_seqn  out  1  decoded bit 9.
- hec_ok  out  1  received HEC equals computed HEC.
- hdr_valid_p  out  1  one-clk_6M pulse; all hdr_* fields and hec_ok are valid.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and LFSRs cleared.
- Bit acceptance: all state updates that consume a bit happen only on clk_6M edges where p_1us=1.
- State IDLE: on rx_trailer_st_p, go to TRAILER.
  - Clear the trailer count, trailer_err, repetition count and bit count.
  - Load the whitening LFSR with whiten_init and the HEC LFSR with regi_uap.
- State TRAILER: consumes 4 bits.
  - Expected sequence in air order is 1,0,1,0 when ref_sync_msb=0, and 0,1,0,1 when ref_sync_msb=1.
  - Any mismatch sets trailer_err. Decoding does not stop.
  - After the 4th bit, go to HEADER.
- State HEADER: bits arrive in groups of 3 (rep counter 0..2).
  - Decoded bit = majority of the 3 samples (2 or more ones gives 1).
  - If whiten_en=1, XOR the decoded bit with whitening LFSR bit 6, then step the LFSR (x^7+x^4+1). If whiten_en=0, the LFSR holds.
  - Decoded bits 0..9 shift LSB-first into the HEC LFSR, polynomial x^8+x^7+x^5+x^2+x+1.
  - Decoded bits 10..17 form hec_rx; the first received bit goes to hec_rx[7].
  - After the 54th raw bit (decoded bit 17), go to CHECK.
- State CHECK: lasts one clk_6M cycle with no p_1us dependency.
  - Register the fields and hec_ok = (hec_rx == HEC LFSR state).
  - Assert hdr_valid_p for exactly this cycle.
  - Go to IDLE.
- Latency: hdr_valid_p rises one clk_6M after the p_1us that carried raw bit 54.
- Field outputs hold until the next hdr_valid_p. trailer_err holds until the next rx_trailer_st_p.
- Restart: rx_trailer_st_p in TRAILER or HEADER restarts from TRAILER with the full IDLE initialisation; no hdr_valid_p is produced for the cut packet.
- rx_abort in any non-IDLE state: go to IDLE, no hdr_valid_p, fields unchanged.
  - rx_abort and rx_trailer_st_p in the same cycle: rx_abort wins.
  - rx_abort in CHECK: hdr_valid_p suppressed.
- rst in mid-operation returns everything to reset values on the next edge.
- Counter widths: trailer count 2 bits, repetition count 2 bits (wraps 2 to 0), bit count 5 bits.
- rx_trailer_st_p and p_1us are coincident. The trailer-start cycle consumes no bit; the first trailer bit is on the next p_1us.

Decomposition:
- Shared package: state enum (IDLE, TRAILER, HEADER, CHECK), HEC polynomial 8'hA7, whitening tap constants, header field bit offsets and widths.
- One sub-module: bt_hec_lfsr.
  - Ports: load, init[7:0], shift, din, crc[7:0].
  - Reusable later by the header transmit path.

Test Plan:
1. ref_sync_msb=0, trailer 1010, header lt_addr=5, type=4'hC, flow=1, arqn=0, seqn=1, whiten_en=0, correct HEC from the model -> one hdr_valid_p, fields 5/C/1/0/1, hec_ok=1, trailer_err=0, 58 strobes after start.
2. Same packet with one corrupted sample in every triple (e.g. 1,1,0 for a 1) -> identical fields, hec_ok=1.
3. ref_sync_msb=1 with trailer 1010 received -> trailer_err=1, header still decoded, hdr_valid_p asserted.
4. whiten_en=1, whiten_init=7'h55, header whitened by the model -> fields match the unwhitened values, hec_ok=1. Flip one HEC triple fully -> hec_ok=0.
5. rx_abort after raw header bit 20 -> busy=0 next cycle, no hdr_valid_p, previous fields unchanged. Second rx_trailer_st_p at header bit 30 -> decode restarts and completes normally.
6. rst asserted in HEADER, released, then a clean packet -> all outputs 0 during reset, then a correct decode.
